// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared encodings for the multicycle controller and ALU control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [3:0] c_st_fetch  = 4'd0;
    localparam logic [3:0] c_st_decode = 4'd1;
    localparam logic [3:0] c_st_memadr = 4'd2;
    localparam logic [3:0] c_st_memrd  = 4'd3;
    localparam logic [3:0] c_st_memwb  = 4'd4;
    localparam logic [3:0] c_st_memwr  = 4'd5;
    localparam logic [3:0] c_st_exec_r = 4'd6;
    localparam logic [3:0] c_st_rwb    = 4'd7;
    localparam logic [3:0] c_st_branch = 4'd8;
    localparam logic [3:0] c_st_jump   = 4'd9;
    localparam logic [3:0] c_st_exec_i = 4'd10;
    localparam logic [3:0] c_st_iwb    = 4'd11;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_sltiu = 6'b001011;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_ori   = 6'b001101;

    localparam logic [2:0] c_alu_add   = 3'b000;
    localparam logic [2:0] c_alu_sub   = 3'b001;
    localparam logic [2:0] c_alu_funct = 3'b010;
    localparam logic [2:0] c_alu_bne   = 3'b011;
    localparam logic [2:0] c_alu_or    = 3'b100;
    localparam logic [2:0] c_alu_lui   = 3'b101;
    localparam logic [2:0] c_alu_sltiu = 3'b110;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_RTYPE   = 3'd1,
        CLS_MEM     = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_IMM     = 3'd5
    } op_class_e;

endpackage

`default_nettype wire

// File: rtl/ctrl_op_class.sv
// ============================================================================
// Module   : ctrl_op_class
// Brief    : Combinational opcode classifier: class, ALU op and illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_op_class
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] i_op,
    output op_class_e       o_class,
    output logic [2:0]      o_alu_op,
    output logic            o_illegal
);

    always_comb begin
        o_class   = CLS_ILLEGAL;
        o_alu_op  = c_alu_add;
        o_illegal = 1'b0;
        case (i_op)
            OP_W'(c_op_rtype): begin o_class = CLS_RTYPE;  o_alu_op = c_alu_funct; end
            OP_W'(c_op_lw),
            OP_W'(c_op_sw):    o_class = CLS_MEM;
            OP_W'(c_op_beq):   begin o_class = CLS_BRANCH; o_alu_op = c_alu_sub;   end
            OP_W'(c_op_bne):   begin o_class = CLS_BRANCH; o_alu_op = c_alu_bne;   end
            OP_W'(c_op_j):     o_class = CLS_JUMP;
            OP_W'(c_op_addi):  o_class = CLS_IMM;
            OP_W'(c_op_sltiu): begin o_class = CLS_IMM;    o_alu_op = c_alu_sltiu; end
            OP_W'(c_op_lui):   begin o_class = CLS_IMM;    o_alu_op = c_alu_lui;   end
            OP_W'(c_op_ori):   begin o_class = CLS_IMM;    o_alu_op = c_alu_or;    end
            default:           o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Moore control FSM for a classic multicycle MIPS-style datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int ST_W    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               BranchNe_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemtoReg_o,
    output logic               RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [1:0]         PCSource_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic [ST_W-1:0]    state_o,
    output logic               illegal_o
);

    localparam logic [ST_W-1:0] c_fetch  = ST_W'(c_st_fetch);
    localparam logic [ST_W-1:0] c_decode = ST_W'(c_st_decode);
    localparam logic [ST_W-1:0] c_memadr = ST_W'(c_st_memadr);
    localparam logic [ST_W-1:0] c_memrd  = ST_W'(c_st_memrd);
    localparam logic [ST_W-1:0] c_memwb  = ST_W'(c_st_memwb);
    localparam logic [ST_W-1:0] c_memwr  = ST_W'(c_st_memwr);
    localparam logic [ST_W-1:0] c_exec_r = ST_W'(c_st_exec_r);
    localparam logic [ST_W-1:0] c_rwb    = ST_W'(c_st_rwb);
    localparam logic [ST_W-1:0] c_branch = ST_W'(c_st_branch);
    localparam logic [ST_W-1:0] c_jump   = ST_W'(c_st_jump);
    localparam logic [ST_W-1:0] c_exec_i = ST_W'(c_st_exec_i);
    localparam logic [ST_W-1:0] c_iwb    = ST_W'(c_st_iwb);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next_state;
    op_class_e       w_class;
    logic [2:0]      w_alu_op;
    logic            w_illegal;
    logic [2:0]      r_alu_op;
    logic            r_is_store;
    logic            r_is_bne;
    logic [2:0]      w_alu_sel;

    ctrl_op_class #(.OP_W(OP_W)) u_op_class (
        .i_op      (instr_op_i),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= c_fetch;
        else        r_state <= w_next_state;
    end

    // Opcode is only sampled in DECODE; later states use these captured attributes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_alu_op   <= c_alu_add;
            r_is_store <= 1'b0;
            r_is_bne   <= 1'b0;
        end else if (r_state == c_decode) begin
            r_alu_op   <= w_alu_op;
            r_is_store <= (instr_op_i == OP_W'(c_op_sw));
            r_is_bne   <= (instr_op_i == OP_W'(c_op_bne));
        end
    end

    always_comb begin
        w_next_state = c_fetch;
        case (r_state)
            c_fetch:  w_next_state = mem_ready_i ? c_decode : c_fetch;
            c_decode: begin
                case (w_class)
                    CLS_RTYPE:  w_next_state = c_exec_r;
                    CLS_MEM:    w_next_state = c_memadr;
                    CLS_BRANCH: w_next_state = c_branch;
                    CLS_JUMP:   w_next_state = c_jump;
                    CLS_IMM:    w_next_state = c_exec_i;
                    default:    w_next_state = c_fetch;
                endcase
            end
            c_memadr: w_next_state = r_is_store ? c_memwr : c_memrd;
            c_memrd:  w_next_state = mem_ready_i ? c_memwb : c_memrd;
            c_memwr:  w_next_state = mem_ready_i ? c_fetch : c_memwr;
            c_exec_r: w_next_state = c_rwb;
            c_exec_i: w_next_state = c_iwb;
            default:  w_next_state = c_fetch;
        endcase
    end

    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        BranchNe_o    = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        PCSource_o    = 2'b00;
        w_alu_sel     = c_alu_add;
        illegal_o     = 1'b0;
        case (r_state)
            c_fetch: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            c_decode: begin
                ALUSrcB_o = 2'b11;
                illegal_o = w_illegal;
            end
            c_memadr: begin ALUSrcA_o = 1'b1; ALUSrcB_o = 2'b10; end
            c_memrd:  begin MemRead_o = 1'b1; IorD_o = 1'b1; end
            c_memwb:  begin RegWrite_o = 1'b1; MemtoReg_o = 1'b1; end
            c_memwr:  begin MemWrite_o = 1'b1; IorD_o = 1'b1; end
            c_exec_r: begin ALUSrcA_o = 1'b1; w_alu_sel = c_alu_funct; end
            c_rwb:    begin RegWrite_o = 1'b1; RegDst_o = 1'b1; end
            c_branch: begin
                ALUSrcA_o     = 1'b1;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                BranchNe_o    = r_is_bne;
                w_alu_sel     = r_alu_op;
            end
            c_jump:   begin PCWrite_o = 1'b1; PCSource_o = 2'b10; end
            c_exec_i: begin ALUSrcA_o = 1'b1; ALUSrcB_o = 2'b10; w_alu_sel = r_alu_op; end
            c_iwb:    RegWrite_o = 1'b1;
            default:  ;
        endcase
        // Reset overrides every enable regardless of the current state.
        if (!rst_i) begin
            PCWrite_o     = 1'b0;
            PCWriteCond_o = 1'b0;
            MemRead_o     = 1'b0;
            MemWrite_o    = 1'b0;
            IRWrite_o     = 1'b0;
            RegWrite_o    = 1'b0;
            illegal_o     = 1'b0;
        end
    end

    assign ALU_op_o = ALUOP_W'(w_alu_sel);
    assign state_o  = r_state;

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: OP_W, default 6, opcode field width.
REQ-002 Parameter: ALUOP_W, default 3, ALU_op_o width.
REQ-003 Parameter: ST_W, default 4, state register width; SHALL be at least 4.
REQ-004 Port: clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port: rst_i, input, 1; reset is synchronous and active-low.
REQ-006 Port: instr_op_i, input, OP_W, opcode from the instruction register; sampled only in DECODE.
REQ-007 Port: mem_ready_i, input, 1, memory handshake; 1 = current access completes this cycle.
REQ-008 Ports, output, 1 each: PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o; meanings per the standard multicycle datapath; BranchNe_o=1 selects inverted zero.
REQ-009 Ports, output, 2 each: ALUSrcB_o (00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2); PCSource_o (00 ALU, 01 ALUOut, 10 jump target).
REQ-010 Port: ALU_op_o, output, ALUOP_W; 000 add, 001 sub/beq, 011 bne, 010 R-type funct, 100 or, 101 lui, 110 sltiu.
REQ-011 Port: state_o, output, ST_W, current state for debug.
REQ-012 Port: illegal_o, output, 1, one-cycle pulse on an unsupported opcode.

Function
REQ-013 States and encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, RWB 7, BRANCH 8, JUMP 9, EXEC_I 10, IWB 11.
REQ-014 All outputs SHALL be Moore (function of state only), except PCWrite_o and IRWrite_o in FETCH, which are gated by mem_ready_i.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000, PCSource=00.
  - While mem_ready_i=0: hold FETCH, no write enables.
  - Cycle mem_ready_i=1: IRWrite=1, PCWrite=1, then go to DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=000; next state from instr_op_i:
  - 000000 -> EXEC_R
  - 100011/101011 -> MEMADR
  - 000100/000101 -> BRANCH
  - 000010 -> JUMP
  - 001000/001011/001111/001101 -> EXEC_I
  - any other opcode -> FETCH, with illegal_o=1 that cycle.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_op=000; go to MEMRD for lw, MEMWR for sw (opcode held stable by IR).
REQ-018 MEMRD: MemRead=1, IorD=1; hold until mem_ready_i=1, then go to MEMWB.
REQ-019 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1 held; on mem_ready_i=1 go to FETCH.
REQ-021 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_op=010; then RWB.
REQ-022 RWB: RegWrite=1, RegDst=1, MemtoReg=0; then FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, PCWriteCond=1, PCSource=01; then FETCH.
  - beq: ALU_op=001, BranchNe=0.
  - bne: ALU_op=011, BranchNe=1.
REQ-024 JUMP: PCWrite=1, PCSource=10; then FETCH.
REQ-025 EXEC_I: ALUSrcA=1, ALUSrcB=10; ALU_op = 000 addi, 110 sltiu, 101 lui, 100 ori; then IWB.
REQ-026 IWB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
REQ-027 Unlisted outputs SHALL be 0 in every state; ALU_op SHALL be 000 where not listed.
REQ-028 Zero-wait latency in cycles, FETCH to next FETCH: R 4, addi/sltiu/lui/ori 4, lw 5, sw 4, beq/bne 3, j 3; each wait cycle in FETCH/MEMRD/MEMWR adds one.
REQ-029 An unreachable state encoding SHALL return to FETCH on the next edge with all enables 0.

Reset
REQ-030 While rst_i=0 at a clock edge, state SHALL become FETCH, from any state including mid-wait.
REQ-031 While rst_i=0, all write/read enables and illegal_o SHALL be 0 regardless of state.
REQ-032 First cycle after rst_i rises: state_o=0, MemRead_o=1.

Structure
REQ-033 Package ctrl_pkg SHALL hold the state encodings, opcode constants and ALU_op codes, shared with the ALU control block.
REQ-034 One sub-module, ctrl_op_class: combinational opcode -> {class, ALU_op, illegal}, used in DECODE and EXEC_I.

Verification
REQ-035 Reset mid-MEMRD (state 3, mem_ready_i=0), rst_i=0 one edge -> state_o=0, MemRead_o=0, RegWrite_o=0.
REQ-036 instr_op_i=000000, mem_ready_i=1 always -> states 0,1,6,7,0; RegWrite_o=1 and RegDst_o=1 only in state 7.
REQ-037 lw (100011), mem_ready_i=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemtoReg_o=1 in state 4.
REQ-038 bne (000101) -> states 0,1,8,0; in state 8: ALU_op_o=011, BranchNe_o=1, PCWriteCond_o=1.
REQ-039 Opcode 111111 -> states 0,1,0; illegal_o=1 exactly one cycle; no RegWrite_o/MemWrite_o/PCWrite_o in state 1.
REQ-040 FETCH with mem_ready_i=0 for 3 cycles -> IRWrite_o=0 and PCWrite_o=0 for 3 cycles, then 1 for exactly one cycle.
